// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
//   Memory-to-memory copy helper that drives the D_MEM port set. Each element
//   is read into a buffer in one cycle (RD) and written back in the next (WR).
//   Arbitration with the CPU load/store path is external.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   START                    request pulse, sampled only while idle
//   SRC_ADDR, DST_ADDR       byte addresses, captured on an accepted START
//   LENGTH                   element count, captured on an accepted START
//   XFER_TYPE                element type, captured on an accepted START
//                            (0 WORD, 1 HALFWORD, 2 UHALFWORD, 3 BYTE, 4 UBYTE)
//   BUSY, DONE, ERR          status: not idle, completion pulse, misalignment
//   MEM_ADDR, MEM_READ, MEM_WRITE, MEM_DATA_TYPE, MEM_WDATA   to D_MEM
//   MEM_RDATA                from D_MEM, combinational read
module dmem_copy_engine #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned ADDRW = 32,
  parameter int unsigned LENW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [ADDRW-1:0] SRC_ADDR,
  input  logic [ADDRW-1:0] DST_ADDR,
  input  logic [LENW-1:0]  LENGTH,
  input  logic [2:0]       XFER_TYPE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [ADDRW-1:0] MEM_ADDR,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic [2:0]       MEM_DATA_TYPE,
  output logic [BITS-1:0]  MEM_WDATA,
  input  logic [BITS-1:0]  MEM_RDATA
);

  localparam logic [2:0] TyWord  = 3'd0;
  localparam logic [2:0] TyHalf  = 3'd1;
  localparam logic [2:0] TyUhalf = 3'd2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  logic [1:0]       r_state;
  logic [ADDRW-1:0] r_src;
  logic [ADDRW-1:0] r_dst;
  logic [LENW-1:0]  r_rem;
  logic [2:0]       r_type;
  logic [BITS-1:0]  r_buf;
  logic             r_err;

  logic [ADDRW-1:0] w_stride;
  logic             w_misalign;

  // Unknown type codes fall back to byte stride.
  function automatic logic [ADDRW-1:0] stride_of(input logic [2:0] t);
    if (t == TyWord) begin
      return ADDRW'(4);
    end else if (t == TyHalf || t == TyUhalf) begin
      return ADDRW'(2);
    end
    return ADDRW'(1);
  endfunction

  function automatic logic misaligned(input logic [ADDRW-1:0] a, input logic [2:0] t);
    if (t == TyWord) begin
      return a[1:0] != 2'b00;
    end else if (t == TyHalf || t == TyUhalf) begin
      return a[0];
    end
    return 1'b0;
  endfunction

  assign w_stride   = stride_of(r_type);
  assign w_misalign = misaligned(SRC_ADDR, XFER_TYPE) | misaligned(DST_ADDR, XFER_TYPE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_type  <= TyWord;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (START) begin
            r_src  <= SRC_ADDR;
            r_dst  <= DST_ADDR;
            r_rem  <= LENGTH;
            r_type <= XFER_TYPE;
            r_err  <= w_misalign;
            if (w_misalign || LENGTH == '0) begin
              r_state <= StFin;
            end else begin
              r_state <= StRd;
            end
          end
        end
        StRd: begin
          r_buf   <= MEM_RDATA;
          r_src   <= r_src + w_stride;
          r_state <= StWr;
        end
        StWr: begin
          r_dst <= r_dst + w_stride;
          r_rem <= r_rem - LENW'(1);
          // Compare before decrement so a full-scale LENGTH never wraps.
          if (r_rem == LENW'(1)) begin
            r_state <= StFin;
          end else begin
            r_state <= StRd;
          end
        end
        StFin: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    BUSY          = (r_state != StIdle);
    DONE          = (r_state == StFin);
    ERR           = r_err;
    MEM_DATA_TYPE = r_type;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDR      = '0;
    MEM_WDATA     = '0;
    if (r_state == StRd) begin
      MEM_READ = 1'b1;
      MEM_ADDR = r_src;
    end else if (r_state == StWr) begin
      MEM_WRITE = 1'b1;
      MEM_ADDR  = r_dst;
      MEM_WDATA = r_buf;
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: a byte-addressed D_MEM model, a reference copy
// model that predicts every output cycle, and literal spot checks.
module tb_dmem_copy_engine;

  localparam logic [2:0] TY_WORD  = 3'd0;
  localparam logic [2:0] TY_HALF  = 3'd1;
  localparam logic [2:0] TY_UHALF = 3'd2;
  localparam logic [2:0] TY_BYTE  = 3'd3;
  localparam logic [2:0] TY_UBYTE = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START = 1'b0;
  logic [31:0] SRC_ADDR = '0;
  logic [31:0] DST_ADDR = '0;
  logic [15:0] LENGTH = '0;
  logic [2:0]  XFER_TYPE = '0;
  logic        BUSY, DONE, ERR, MEM_READ, MEM_WRITE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [2:0]  MEM_DATA_TYPE;

  always #5 clk = ~clk;

  dmem_copy_engine #(.BITS(32), .ADDRW(32), .LENW(16)) dut (
    .clk(clk), .rst(rst), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .LENGTH(LENGTH), .XFER_TYPE(XFER_TYPE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_DATA_TYPE(MEM_DATA_TYPE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  function automatic logic [31:0] ext(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3,
                                      input logic [2:0] t);
    case (t)
      TY_WORD:  return {b3, b2, b1, b0};
      TY_HALF:  return {{16{b1[7]}}, b1, b0};
      TY_UHALF: return {16'h0000, b1, b0};
      TY_BYTE:  return {{24{b0[7]}}, b0};
      default:  return {24'h000000, b0};
    endcase
  endfunction

  // D_MEM model: 1 KiB, little-endian, combinational read
  logic [7:0]  mem [0:1023];
  logic        tb_we = 1'b0, tb_clr = 1'b1;
  logic [9:0]  tb_wa = '0;
  logic [2:0]  tb_wt = '0;
  logic [31:0] tb_wd = '0;
  logic        w_we;
  logic [9:0]  w_wa, ra;
  logic [2:0]  w_wt;
  logic [31:0] w_wd;

  assign ra   = MEM_ADDR[9:0];
  assign w_we = MEM_WRITE | tb_we;
  assign w_wa = MEM_WRITE ? MEM_ADDR[9:0] : tb_wa;
  assign w_wt = MEM_WRITE ? MEM_DATA_TYPE : tb_wt;
  assign w_wd = MEM_WRITE ? MEM_WDATA : tb_wd;

  always_comb MEM_RDATA = ext(mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3],
                              MEM_DATA_TYPE);

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (w_we) begin
      mem[w_wa] <= w_wd[7:0];
      if (w_wt != TY_BYTE && w_wt != TY_UBYTE) mem[w_wa + 10'd1] <= w_wd[15:8];
      if (w_wt == TY_WORD) begin
        mem[w_wa + 10'd2] <= w_wd[23:16];
        mem[w_wa + 10'd3] <= w_wd[31:24];
      end
    end
  end

  function automatic logic [31:0] dmem_rd(input logic [31:0] a, input logic [2:0] t);
    logic [9:0] i;
    i = a[9:0];
    return ext(mem[i], mem[i + 10'd1], mem[i + 10'd2], mem[i + 10'd3], t);
  endfunction

  // Reference model
  typedef struct {
    logic        busy, done, rd, wr;
    logic [31:0] addr, wdata;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:1023];
  logic        err_exp = 1'b0;
  logic [2:0]  cur_type = TY_WORD;
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [2:0] t);
    logic [9:0] i;
    i = a[9:0];
    return ext(ref_mem[i], ref_mem[i + 10'd1], ref_mem[i + 10'd2], ref_mem[i + 10'd3], t);
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v);
    logic [9:0] i;
    i = a[9:0];
    ref_mem[i] = v[7:0];
    if (t != TY_BYTE && t != TY_UBYTE) ref_mem[i + 10'd1] = v[15:8];
    if (t == TY_WORD) begin
      ref_mem[i + 10'd2] = v[23:16];
      ref_mem[i + 10'd3] = v[31:24];
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    case (t)
      TY_WORD:           return 4;
      TY_HALF, TY_UHALF: return 2;
      default:           return 1;
    endcase
  endfunction

  task automatic model_start(input logic [31:0] src, input logic [31:0] dst,
                             input int n, input logic [2:0] t);
    int          sz;
    logic [31:0] v, a, d;
    sz       = size_of(t);
    cur_type = t;
    err_exp  = (src % sz != 0) || (dst % sz != 0);
    if (!err_exp) begin
      for (int i = 0; i < n; i++) begin
        a = src + 32'(i * sz);
        d = dst + 32'(i * sz);
        v = ref_rd(a, t);
        q.push_back('{busy: 1'b1, done: 1'b0, rd: 1'b1, wr: 1'b0, addr: a, wdata: 32'h0});
        q.push_back('{busy: 1'b1, done: 1'b0, rd: 1'b0, wr: 1'b1, addr: d, wdata: v});
        ref_wr(d, t, v);
      end
    end
    q.push_back('{busy: 1'b1, done: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0});
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic cycle_check();
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '{busy: 1'b0, done: 1'b0, rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0};
    check("cyc_busy", 32'(BUSY), 32'(e.busy));
    check("cyc_done", 32'(DONE), 32'(e.done));
    check("cyc_read", 32'(MEM_READ), 32'(e.rd));
    check("cyc_write", 32'(MEM_WRITE), 32'(e.wr));
    check("cyc_addr", MEM_ADDR, e.addr);
    check("cyc_wdata", MEM_WDATA, e.wdata);
    check("cyc_err", 32'(ERR), 32'(err_exp));
    check("cyc_type", 32'(MEM_DATA_TYPE), 32'(cur_type));
  endtask

  // All bench tasks begin and end 1 time unit after a rising edge.
  task automatic preload(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v);
    tb_we = 1'b1; tb_wa = a[9:0]; tb_wt = t; tb_wd = v;
    ref_wr(a, t, v);
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] src, input logic [31:0] dst,
                          input int n, input logic [2:0] t);
    START = 1'b1; SRC_ADDR = src; DST_ADDR = dst; LENGTH = 16'(n); XFER_TYPE = t;
    @(posedge clk); #1;
    START = 1'b0;
    model_start(src, dst, n, t);
  endtask

  // Runs one copy, checks the START-to-DONE latency; inj pulses a stray START.
  task automatic run(input string nm, input logic [31:0] src, input logic [31:0] dst,
                     input int n, input logic [2:0] t, input int want_lat, input bit inj);
    int lat;
    lat = 0;
    do_start(src, dst, n, t);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (inj && c == 3) begin
        START = 1'b1; SRC_ADDR = 32'h0000_0200; DST_ADDR = 32'h0000_0300; LENGTH = 16'd2;
        XFER_TYPE = TY_BYTE;
      end
      if (inj && c == 4) START = 1'b0;
      if (DONE) begin
        lat = c;
        break;
      end
    end
    check({nm, "_done_latency"}, 32'(lat), 32'(want_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) cycle_check();
      end
    join_none

    @(posedge clk); #1;
    tb_clr = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    check("rst_rw", {30'h0, MEM_READ, MEM_WRITE}, 32'h0);
    check("rst_addr", MEM_ADDR, 32'h0);
    check("rst_wdata", MEM_WDATA, 32'h0);
    check("rst_type", 32'(MEM_DATA_TYPE), 32'(TY_WORD));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // WORD copy with a stray START while busy
    preload(32'h000, TY_WORD, 32'h1111_1111);
    preload(32'h004, TY_WORD, 32'h2222_2222);
    preload(32'h008, TY_WORD, 32'h3333_3333);
    preload(32'h00C, TY_WORD, 32'h4444_4444);
    run("word", 32'h000, 32'h100, 4, TY_WORD, 9, 1'b1);
    check("word_dst0", dmem_rd(32'h100, TY_WORD), 32'h1111_1111);
    check("word_dst1", dmem_rd(32'h104, TY_WORD), 32'h2222_2222);
    check("word_dst2", dmem_rd(32'h108, TY_WORD), 32'h3333_3333);
    check("word_dst3", dmem_rd(32'h10C, TY_WORD), 32'h4444_4444);
    check("word_src3", dmem_rd(32'h00C, TY_WORD), 32'h4444_4444);
    check("stray_untouched", dmem_rd(32'h300, TY_WORD), 32'h0);

    // BYTE copy to an odd destination
    preload(32'h040, TY_UBYTE, 32'hAA);
    preload(32'h046, TY_UBYTE, 32'hBB);
    for (int i = 0; i < 5; i++) preload(32'h020 + 32'(i), TY_BYTE, 32'h80 + 32'(i));
    run("byte", 32'h020, 32'h041, 5, TY_BYTE, 11, 1'b0);
    for (int i = 0; i < 5; i++)
      check($sformatf("byte_dst%0d", i), dmem_rd(32'h041 + 32'(i), TY_UBYTE), 32'h80 + 32'(i));
    check("byte_below", dmem_rd(32'h040, TY_UBYTE), 32'hAA);
    check("byte_above", dmem_rd(32'h046, TY_UBYTE), 32'hBB);

    // Signed halfword
    preload(32'h010, TY_UHALF, 32'h8002);
    run("half", 32'h010, 32'h200, 1, TY_HALF, 3, 1'b0);
    check("half_signed", dmem_rd(32'h200, TY_HALF), 32'hFFFF_8002);
    check("half_unsigned", dmem_rd(32'h200, TY_UHALF), 32'h0000_8002);

    // Misaligned, then zero length
    run("misalign", 32'h102, 32'h300, 2, TY_WORD, 1, 1'b0);
    check("misalign_err", 32'(ERR), 32'h1);
    check("misalign_nowrite", dmem_rd(32'h300, TY_WORD), 32'h0);
    run("zero_len", 32'h000, 32'h300, 0, TY_WORD, 1, 1'b0);
    check("zero_len_err", 32'(ERR), 32'h0);

    // Reset during a WR cycle (in-place copy so memory is unchanged either way)
    do_start(32'h100, 32'h100, 4, TY_WORD);
    @(posedge clk); #2;
    chk_en = 1'b0;
    check("pre_rst_write", 32'(MEM_WRITE), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_write", 32'(MEM_WRITE), 32'h0);
    check("async_rst_busy", 32'(BUSY), 32'h0);
    q.delete();
    err_exp = 1'b0;
    cur_type = TY_WORD;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run("after_rst", 32'h020, 32'h060, 5, TY_UBYTE, 11, 1'b0);
    check("after_rst_b4", dmem_rd(32'h064, TY_UBYTE), 32'h84);
    check("word_dst_kept", dmem_rd(32'h104, TY_WORD), 32'h2222_2222);

    // Whole memory against the reference
    diffs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (diffs < 8) $display("FAIL mem_byte[%0d]: got %h want %h", i, mem[i], ref_mem[i]);
        diffs++;
      end
    end
    check("mem_image_diffs", 32'(diffs), 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
Initiator-side block that drives the data memory (D_MEM) port set to copy a block of elements from a source region to a destination region.
Each element is read through the same MEM_READ/MEM_ADDR/MEM_DATA_TYPE interface the CPU uses, buffered, then written back.
It sits beside the CPU load/store path and serves as the memory-to-memory copy helper for the image coprocessor buffers. Arbitration with the CPU port is external.

Parameters:
BITS, 32, data width; matches common_params
ADDRW, 32, byte-address width; matches common_params
LENW, 16, element-count width

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
START  in  1  request pulse; sampled only in IDLE
SRC_ADDR  in  ADDRW  source byte address; captured on accepted START
DST_ADDR  in  ADDRW  destination byte address; captured on accepted START
LENGTH  in  LENW  element count; captured on accepted START
XFER_TYPE  in  mem_data_t  element type (WORD/HALFWORD/UHALFWORD/BYTE/UBYTE); captured on accepted START
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle completion pulse
ERR  out  1  misalignment flag; held until next accepted START
MEM_ADDR  out  ADDRW  to D_MEM MEM_ADDR
MEM_READ  out  1  to D_MEM MEM_READ
MEM_WRITE  out  1  to D_MEM MEM_WRITE
MEM_DATA_TYPE  out  mem_data_t  to D_MEM MEM_DATA_TYPE; driven with the captured type
MEM_WDATA  out  BITS  to D_MEM MEM_DATA_IN
MEM_RDATA  in  BITS  from D_MEM MEM_DATA_OUT; combinational read, valid in the same cycle as the address

Behaviour:
- Reset (async): state=IDLE; BUSY=0, DONE=0, ERR=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_DATA_TYPE=WORD; internal address, count and buffer registers cleared.
- Reset asserted mid-transfer: MEM_WRITE drops immediately (asynchronously). The partial copy is abandoned and no DONE is issued.
- Stride: 4 for WORD; 2 for HALFWORD/UHALFWORD; 1 for BYTE/UBYTE.
- States: IDLE, RD, WR, FIN. Outputs are decoded from registered state and registers.
- IDLE: memory controls are 0.
  - On START=1: capture SRC_ADDR, DST_ADDR, LENGTH and XFER_TYPE; clear ERR.
  - If the source or destination address is misaligned for the stride, set ERR=1 and go to FIN. No memory access occurs.
  - Else if LENGTH==0, go to FIN.
  - Else go to RD.
- START outside IDLE is ignored, and inputs are not re-captured.
- RD (1 cycle): MEM_READ=1, MEM_ADDR=src pointer, MEM_WRITE=0.
  - On the edge: buffer <= MEM_RDATA; src pointer += stride; go to WR.
- WR (1 cycle): MEM_WRITE=1, MEM_ADDR=dst pointer, MEM_WDATA=buffer, MEM_READ=0.
  - On the edge: dst pointer += stride; remaining -= 1.
  - If remaining becomes 0, go to FIN; else go to RD.
- FIN (1 cycle): DONE=1, BUSY=1, memory controls 0; then go to IDLE.
- MEM_READ and MEM_WRITE are never high in the same cycle.
- Latency: START sampled at edge k gives RD in cycle k+1. For N>0 elements, DONE is high in cycle k+2N+1. Error or N==0 gives DONE in cycle k+1.
- Pointers wrap modulo 2^ADDRW. Overlapping regions are copied in ascending element order with no hazard protection.
- Signed types: the buffer holds the sign-extended value, and D_MEM stores only the low bytes on write. The destination bytes therefore equal the source bytes.
- LENGTH = 2^LENW-1 is legal; the counter must not overflow.

Test Plan:
- WORD copy: preload 0x000-0x00C with 0x11111111, 0x22222222, 0x33333333, 0x44444444; START src=0x000, dst=0x100, LEN=4 -> BUSY for 9 cycles, DONE pulse at k+9; word reads at 0x100-0x10C return the same values; source unchanged.
- BYTE copy: preload bytes 0x80..0x84 at 0x20; START type=BYTE, src=0x20, dst=0x41, LEN=5 -> UBYTE reads at 0x41..0x45 return 0x80..0x84; byte 0x40 and byte 0x46 are untouched.
- HALFWORD signed copy: source halfword 0x8002 at 0x10 -> HALFWORD read at dst returns 0xFFFF8002, UHALFWORD read returns 0x00008002.
- Misaligned and zero-length requests:
  - WORD with src=0x102 -> ERR=1 and DONE at k+1; MEM_READ and MEM_WRITE never assert.
  - LEN=0 -> DONE at k+1 with ERR=0.
- START pulsed while BUSY with different addresses -> ignored; the original copy completes unchanged.
- Assert rst during a WR cycle -> MEM_WRITE=0 within the same cycle; after release, BUSY=0 and DONE stays 0; a new START operates normally.
